// File: rtl/pca9685_regs.sv
`default_nettype none
// ============================================================================
// pca9685_regs : PCA9685-style register bank (shadowed LED regs) + PWM engine
// Revision     : 1.0
// ============================================================================
module pca9685_regs #(
  parameter int NUM_CH = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ptr_load_i,
  input  logic [7:0]        ptr_i,
  input  logic              wr_i,
  input  logic [7:0]        wdata_i,
  input  logic              rd_i,
  output logic [7:0]        rdata_o,
  input  logic              stop_i,
  output logic [NUM_CH-1:0] pwm_o
);

  localparam int         CW         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [7:0] c_last_led = 8'(5 + 4 * NUM_CH);

  logic [7:0]        mode1_q, mode1_d, mode2_q, mode2_d;
  logic [7:0]        prescale_q, prescale_d, ptr_q, ptr_d, rdata_q, rdata_d;
  logic [7:0]        pre_cnt_q, pre_cnt_d;
  logic [11:0]       cnt_q, cnt_d;
  logic [NUM_CH-1:0] pwm_q, pwm_d;
  logic [7:0]        sh_q [NUM_CH][4];
  logic [7:0]        sh_d [NUM_CH][4];
  // Active copy packed as {OFF_H[4:0], OFF_L, ON_H[4:0], ON_L}.
  logic [25:0]       act_q [NUM_CH];
  logic [25:0]       act_d [NUM_CH];

  logic          w_sleep, w_ai, w_invrt;
  logic [7:0]    w_led_off, w_rd_byte, w_led_mask, w_all_mask;
  logic [CW-1:0] w_led_ch;
  logic [1:0]    w_led_b, w_all_b;
  logic          w_led_hit, w_all_hit;

  assign w_sleep    = mode1_q[4];
  assign w_ai       = mode1_q[5];
  assign w_invrt    = mode2_q[4];
  assign w_led_off  = ptr_q - 8'd6;
  assign w_led_ch   = CW'(w_led_off >> 2);
  assign w_led_b    = w_led_off[1:0];
  assign w_led_hit  = (ptr_q >= 8'd6) && (ptr_q <= c_last_led);
  assign w_all_hit  = (ptr_q >= 8'hFA) && (ptr_q <= 8'hFD);
  // 0xFA..0xFD map onto byte lanes 0..3 of every channel.
  assign w_all_b    = ptr_q[1:0] ^ 2'b10;
  assign w_led_mask = w_led_b[0] ? 8'h1F : 8'hFF;
  assign w_all_mask = w_all_b[0] ? 8'h1F : 8'hFF;

  always_comb begin
    w_rd_byte = 8'h00;
    if (ptr_q == 8'h00)      w_rd_byte = mode1_q;
    else if (ptr_q == 8'h01) w_rd_byte = mode2_q;
    else if (w_led_hit)      w_rd_byte = sh_q[w_led_ch][w_led_b];
    else if (ptr_q == 8'hFE) w_rd_byte = prescale_q;
  end

  always_comb begin
    ptr_d      = ptr_q;
    mode1_d    = mode1_q;
    mode2_d    = mode2_q;
    prescale_d = prescale_q;
    rdata_d    = rdata_q;
    sh_d       = sh_q;
    act_d      = act_q;
    // The copy reads sh_q, so a same-cycle write is only seen at the next stop.
    if (stop_i) begin
      for (int i = 0; i < NUM_CH; i++)
        act_d[i] = {sh_q[i][3][4:0], sh_q[i][2], sh_q[i][1][4:0], sh_q[i][0]};
    end
    if (ptr_load_i) begin
      ptr_d = ptr_i;
    end else if (wr_i || rd_i) begin
      if (wr_i) begin
        if (ptr_q == 8'h00)      mode1_d = wdata_i;
        else if (ptr_q == 8'h01) mode2_d = wdata_i;
        else if (w_led_hit)      sh_d[w_led_ch][w_led_b] = wdata_i & w_led_mask;
        else if (w_all_hit) begin
          for (int i = 0; i < NUM_CH; i++) sh_d[i][w_all_b] = wdata_i & w_all_mask;
        end else if ((ptr_q == 8'hFE) && w_sleep) begin
          prescale_d = (wdata_i < 8'd3) ? 8'd3 : wdata_i;
        end
      end else begin
        rdata_d = w_rd_byte;
      end
      if (w_ai) ptr_d = ((ptr_q == c_last_led) || (ptr_q == 8'hFF)) ? 8'h00 : ptr_q + 8'd1;
    end
  end

  always_comb begin
    pre_cnt_d = pre_cnt_q;
    cnt_d     = cnt_q;
    if (w_sleep) begin
      pre_cnt_d = 8'h00;
      cnt_d     = 12'h000;
    end else if (pre_cnt_q >= prescale_q) begin
      pre_cnt_d = 8'h00;
      cnt_d     = cnt_q + 12'd1;
    end else begin
      pre_cnt_d = pre_cnt_q + 8'd1;
    end
  end

  function automatic logic f_raw(input logic [25:0] a, input logic [11:0] cnt);
    logic [11:0] on_v, off_v;
    on_v  = {a[11:8], a[7:0]};
    off_v = {a[24:21], a[20:13]};
    if (a[25])         return 1'b0;
    if (a[12])         return 1'b1;
    if (on_v < off_v)  return (cnt >= on_v) && (cnt < off_v);
    if (on_v > off_v)  return (cnt >= on_v) || (cnt < off_v);
    return 1'b0;
  endfunction

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_pwm
    assign pwm_d[gi] = ~w_sleep & (f_raw(act_q[gi], cnt_q) ^ w_invrt);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode1_q    <= 8'h11;
      mode2_q    <= 8'h04;
      prescale_q <= 8'h1E;
      ptr_q      <= 8'h00;
      rdata_q    <= 8'h00;
      pre_cnt_q  <= 8'h00;
      cnt_q      <= 12'h000;
      pwm_q      <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        sh_q[i]  <= '{8'h00, 8'h00, 8'h00, 8'h10};
        act_q[i] <= {5'h10, 21'h0};
      end
    end else begin
      mode1_q    <= mode1_d;
      mode2_q    <= mode2_d;
      prescale_q <= prescale_d;
      ptr_q      <= ptr_d;
      rdata_q    <= rdata_d;
      pre_cnt_q  <= pre_cnt_d;
      cnt_q      <= cnt_d;
      pwm_q      <= pwm_d;
      sh_q       <= sh_d;
      act_q      <= act_d;
    end
  end

  assign rdata_o = rdata_q;
  assign pwm_o   = pwm_q;

endmodule
`default_nettype wire

// File: doc/pca9685_regs.md
# pca9685_regs

PCA9685-compatible register bank and PWM engine, downstream of the I2C target. The I2C target delivers a pointer load and then byte reads and writes. This block holds the register pointer and auto-increments it, stores MODE, LED and PRE_SCALE registers, and returns read data. It drives NUM_CH 12-bit PWM outputs from a shared prescaler and counter.

## Interface
- NUM_CH, 16: number of PWM channels, 1..16.
- clk_i  in  1  system clock (27 MHz).
- rst_i  in  1  reset; synchronous and active-high.
- ptr_load_i  in  1  one-cycle pulse: register pointer <= ptr_i.
- ptr_i  in  8  register address from the I2C register-ID byte.
- wr_i  in  1  one-cycle pulse: write wdata_i to reg[pointer].
- wdata_i  in  8  write byte.
- rd_i  in  1  one-cycle pulse: fetch reg[pointer] into rdata_o.
- rdata_o  out  8  read byte, registered.
- stop_i  in  1  one-cycle pulse on I2C STOP: copy LED shadow registers to active registers.
- pwm_o  out  NUM_CH  PWM outputs, registered.

## Operation
- Register map:
  - 0x00 MODE1: bit5 AI (auto-increment), bit4 SLEEP. Other bits are storage only.
  - 0x01 MODE2: bit4 INVRT. Other bits are storage only.
  - 0x06+4n..0x09+4n for n < NUM_CH: LEDn_ON_L, ON_H, OFF_L, OFF_H.
    - ON = {ON_H[3:0], ON_L}; ON_H[4] = full-on.
    - OFF = {OFF_H[3:0], OFF_L}; OFF_H[4] = full-off.
    - Bits [7:5] of ON_H and OFF_H read 0.
  - 0xFA..0xFD ALL_LED_*: write-only. A write updates the same byte in every channel's shadow. Reads return 0.
  - 0xFE PRE_SCALE: writable only when SLEEP=1, otherwise the write is dropped. Values below 3 are stored as 3.
  - All other addresses read 0 and ignore writes.
- Reset values:
  - MODE1 = 0x11, MODE2 = 0x04, PRE_SCALE = 0x1E.
  - LED shadow and active: all bytes 0 except OFF_H = 0x10 (full-off).
  - pointer = 0, rdata_o = 0, pwm_o = 0, prescaler = 0, counter = 0.
- Writes and reads of LED registers act on the shadow copy. On stop_i, every active LED register <= its shadow.
- Auto-increment, applied after every wr_i or rd_i when AI=1:
  - pointer == 0x05+4*NUM_CH (last LED byte) -> 0x00.
  - pointer == 0xFF -> 0x00.
  - otherwise pointer + 1.
  - AI=0: pointer unchanged.
- Priority within one cycle: rst_i > ptr_load_i > wr_i > rd_i. A lower-priority pulse in the same cycle is dropped and does not increment the pointer.
- stop_i in the same cycle as wr_i: the copy uses the pre-write shadow. The written byte reaches the active registers at the next stop_i.
- PWM engine:
  - The prescaler counts 0..PRE_SCALE and emits a tick on wrap, so the tick period is PRE_SCALE+1 clk_i cycles.
  - The 12-bit counter increments on each tick and wraps 4095 -> 0.
  - SLEEP=1 holds the prescaler and counter at 0 and forces pwm_o = 0 (no inversion).
- Raw level per channel, from active registers, in priority order:
  1. full-off -> 0.
  2. else full-on -> 1.
  3. else ON < OFF -> (ON <= cnt < OFF).
  4. else ON > OFF -> (cnt >= ON or cnt < OFF).
  5. else (ON == OFF) -> 0.
- pwm_o = raw level XOR INVRT, except while SLEEP=1 (forced 0).

## Timing
- ptr_load_i / wr_i: the register or pointer is updated at the clock edge of the pulse. A read issued on the next cycle sees the new value.
- rd_i: rdata_o is valid 1 cycle after the pulse and holds until the next accepted rd_i. The data is fetched from the pointer value before the increment.
- stop_i: active registers are updated at the edge of the pulse. pwm_o reflects them from the following cycle.
- pwm_o is registered: it lags the counter/register state by 1 clk_i.
- SLEEP 1->0: the prescaler starts from 0. The first tick arrives PRE_SCALE+1 cycles after the MODE1 write edge.
- rst_i mid-operation restores every reset value on the next edge, including a pending shadow copy and a partially counted prescale.

## Test plan
- Reset readback: ptr_load 0x00, AI off, rd -> rdata_o 0x11. ptr 0xFE -> 0x1E. ptr 0x09 -> 0x10. pwm_o = 0.
- PRE_SCALE lock:
  - SLEEP=1, write 0xFE = 0x05 -> reads 0x05.
  - MODE1 = 0x20 (awake, AI), write 0xFE = 0x09 -> still 0x05.
  - Write 0xFE = 0x01 while asleep -> reads 0x03.
- Auto-increment burst with MODE1 = 0x20, PRE_SCALE = 3:
  - ptr_load 0x06, write 0x00, 0x00, 0x00, 0x08 (OFF = 2048); pwm_o[0] stays old until stop_i.
  - After stop_i: high for counter 0..2047, with a period of 16384 clk_i.
  - A read burst from 0x06 returns the same 4 bytes.
- Wrap window: ON = 3000, OFF = 1000 -> high for counter >= 3000 or < 1000. ON = OFF = 500 -> always low.
- Priority and inversion: OFF_H = 0x10 with ON_H = 0x10 -> low. INVRT = 1 -> high. SLEEP = 1 -> 0.
- ALL_LED and wrap: write 0xFD = 0x10, then stop -> every channel low. AI pointer at 0x45 (NUM_CH = 16): rd -> next pointer 0x00. wr and rd in the same cycle -> only the write takes effect, single increment.
